// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one command at a time, fixed-length
// read/write strobe windows, write recovery cycle, all pin outputs registered.
module sram_ctrl #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  localparam int BL     = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [BL-1:0] be,
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [BL-1:0] sram_be_n,
  output logic [1:0]    state_dbg
);

  if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
    $error("sram_ctrl: DW must be a non-zero multiple of 8");
  end
  if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
    $error("sram_ctrl: RD_WAIT and WR_WAIT must be in 0..15");
  end

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    WREC = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          capture;
  logic          ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [BL-1:0] be_n_d;

  // Handshake: a command transfers on a rising edge where req and ready are both
  // high; ready is high exactly while idle, and req/we/addr/wdata/be are only
  // looked at on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (we) begin
            state_d = WR;
            cnt_d   = WR_CNT;
          end else begin
            state_d = RD;
            cnt_d   = RD_CNT;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR: begin
        if (cnt_q == 4'd0) state_d = WREC;
        else cnt_d = cnt_q - 4'd1;
      end
      WREC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they line up with the state.
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR);
    dq_oe_d = (state_d == WR) || (state_d == WREC);
    case (state_d)
      IDLE:    be_n_d = '1;
      RD:      be_n_d = '0;
      default: be_n_d = accept ? ~be : sram_be_n;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready      <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
    end else begin
      ready      <= (state_d == IDLE);
      rvalid     <= capture;
      if (capture) rdata <= sram_dq_i;
      if (accept) sram_a <= addr;
      if (accept && we) sram_dq_o <= wdata;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_be_n  <= be_n_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default build with SRAM model, zero-wait build for command
// spacing, and a 32-bit/RD_WAIT=5 build for byte lanes and read latency.
module tb_sram_ctrl;

  localparam int A_RD = 2;
  localparam int A_WR = 2;
  localparam int C_RD = 5;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err = 0;
  int   conflicts = 0;

  // instance A: AW=18 DW=16 RD_WAIT=2 WR_WAIT=2
  logic        a_req, a_we, a_ready, a_rvalid, a_dqoe, a_ce, a_oe, a_we_n;
  logic [17:0] a_addr, a_sa;
  logic [15:0] a_wdata, a_rdata, a_dqo;
  logic [15:0] a_dqi = 16'h0;
  logic [1:0]  a_be, a_be_n, a_st;

  // instance B: RD_WAIT=0 WR_WAIT=0
  logic        b_req, b_we, b_ready, b_rvalid, b_dqoe, b_ce, b_oe, b_we_n;
  logic [17:0] b_addr, b_sa;
  logic [15:0] b_wdata, b_rdata, b_dqo;
  logic [1:0]  b_be, b_be_n, b_st;

  // instance C: AW=20 DW=32 RD_WAIT=5
  logic        c_req, c_we, c_ready, c_rvalid, c_dqoe, c_ce, c_oe, c_we_n;
  logic [19:0] c_addr, c_sa;
  logic [31:0] c_wdata, c_rdata, c_dqo;
  logic [31:0] c_dqi = 32'h0;
  logic [3:0]  c_be, c_be_n;
  logic [1:0]  c_st;

  logic [15:0] a_exp_q[$];
  logic [31:0] c_exp_q[$];
  logic [15:0] a_shadow [logic [17:0]];
  logic [15:0] a_mem [logic [17:0]];
  logic [31:0] c_mem [logic [19:0]];
  int          a_we_lo = 0;

  sram_ctrl #(.AW(18), .DW(16), .RD_WAIT(A_RD), .WR_WAIT(A_WR)) u_a (
    .clk(clk), .reset(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .be(a_be), .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata), .sram_a(a_sa),
    .sram_dq_o(a_dqo), .sram_dq_oe(a_dqoe), .sram_dq_i(a_dqi), .sram_ce_n(a_ce),
    .sram_oe_n(a_oe), .sram_we_n(a_we_n), .sram_be_n(a_be_n), .state_dbg(a_st));

  sram_ctrl #(.AW(18), .DW(16), .RD_WAIT(0), .WR_WAIT(0)) u_b (
    .clk(clk), .reset(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .be(b_be), .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata), .sram_a(b_sa),
    .sram_dq_o(b_dqo), .sram_dq_oe(b_dqoe), .sram_dq_i(16'h3C3C), .sram_ce_n(b_ce),
    .sram_oe_n(b_oe), .sram_we_n(b_we_n), .sram_be_n(b_be_n), .state_dbg(b_st));

  sram_ctrl #(.AW(20), .DW(32), .RD_WAIT(C_RD), .WR_WAIT(2)) u_c (
    .clk(clk), .reset(rst), .req(c_req), .we(c_we), .addr(c_addr), .wdata(c_wdata),
    .be(c_be), .ready(c_ready), .rvalid(c_rvalid), .rdata(c_rdata), .sram_a(c_sa),
    .sram_dq_o(c_dqo), .sram_dq_oe(c_dqoe), .sram_dq_i(c_dqi), .sram_ce_n(c_ce),
    .sram_oe_n(c_oe), .sram_we_n(c_we_n), .sram_be_n(c_be_n), .state_dbg(c_st));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM models: data launched at negedge; a write lands only when WE rises
  // while CE is still low and the data bus is still driven.
  always @(negedge clk) begin : a_model
    logic        pend;
    logic [17:0] pa;
    logic [15:0] pd, cur;
    logic [1:0]  pbn;
    if (!a_ce && !a_oe) a_dqi = a_mem.exists(a_sa) ? a_mem[a_sa] : 16'h0;
    else a_dqi = 16'hDEAD;
    if (!a_ce && !a_we_n) begin
      pend = 1'b1; pa = a_sa; pd = a_dqo; pbn = a_be_n;
    end else if (pend) begin
      if (!a_ce && a_dqoe) begin
        cur = a_mem.exists(pa) ? a_mem[pa] : 16'h0;
        for (int i = 0; i < 2; i++) if (!pbn[i]) cur[8*i +: 8] = pd[8*i +: 8];
        a_mem[pa] = cur;
      end
      pend = 1'b0;
    end
    if (!a_we_n) a_we_lo++;
  end

  always @(negedge clk) begin : c_model
    logic        pend;
    logic [19:0] pa;
    logic [31:0] pd, cur;
    logic [3:0]  pbn;
    if (!c_ce && !c_oe) c_dqi = c_mem.exists(c_sa) ? c_mem[c_sa] : 32'h0;
    else c_dqi = 32'hDEADBEEF;
    if (!c_ce && !c_we_n) begin
      pend = 1'b1; pa = c_sa; pd = c_dqo; pbn = c_be_n;
    end else if (pend) begin
      if (!c_ce && c_dqoe) begin
        cur = c_mem.exists(pa) ? c_mem[pa] : 32'h0;
        for (int i = 0; i < 4; i++) if (!pbn[i]) cur[8*i +: 8] = pd[8*i +: 8];
        c_mem[pa] = cur;
      end
      pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if ((!a_oe && a_dqoe) || (!b_oe && b_dqoe) || (!c_oe && c_dqoe)) conflicts++;
  end

  // scoreboard
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (a_exp_q.size() != 0) check("a_rdata", 64'(a_rdata), 64'(a_exp_q.pop_front()));
      else begin
        n_checks++; n_err++;
        $error("FAIL a_rvalid_unexpected observed=1 expected=0");
      end
    end
    if (c_rvalid) begin
      if (c_exp_q.size() != 0) check("c_rdata", 64'(c_rdata), 64'(c_exp_q.pop_front()));
      else begin
        n_checks++; n_err++;
        $error("FAIL c_rvalid_unexpected observed=1 expected=0");
      end
    end
  end

  // driver tasks
  task automatic a_issue(input logic w, input logic [17:0] ad, input logic [15:0] d,
                         input logic [1:0] b);
    int t = 0;
    @(negedge clk);
    while (!a_ready && t < 100) begin @(negedge clk); t++; end
    check("a_ready_wait", 64'(a_ready), 64'(1));
    a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = d; a_be = b;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic a_write(input logic [17:0] ad, input logic [15:0] d, input logic [1:0] b);
    int lo0;
    logic [15:0] cur;
    a_issue(1'b1, ad, d, b);
    lo0 = a_we_lo;
    check("a_wr_bus", 64'({a_ce, a_oe, a_we_n, a_be_n, a_dqoe, a_sa, a_dqo}),
          64'({1'b0, 1'b1, 1'b0, ~b, 1'b1, ad, d}));
    repeat (A_WR + 1) @(posedge clk);
    #1;
    check("a_wrec_bus", 64'({a_ce, a_oe, a_we_n, a_dqoe, a_dqo, a_sa}),
          64'({1'b0, 1'b1, 1'b1, 1'b1, d, ad}));
    @(posedge clk); #1;
    check("a_wr_idle", 64'({a_ready, a_ce, a_oe, a_we_n, a_be_n, a_dqoe}),
          64'({1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0}));
    check("a_we_pulse", 64'(a_we_lo - lo0), 64'(A_WR + 1));
    cur = a_shadow.exists(ad) ? a_shadow[ad] : 16'h0;
    for (int i = 0; i < 2; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
    a_shadow[ad] = cur;
  endtask

  task automatic a_read(input logic [17:0] ad);
    int k = 0;
    a_exp_q.push_back(a_shadow.exists(ad) ? a_shadow[ad] : 16'h0);
    a_issue(1'b0, ad, 16'h0, 2'b00);
    check("a_rd_bus", 64'({a_ce, a_oe, a_we_n, a_be_n, a_dqoe, a_sa}),
          64'({1'b0, 1'b0, 1'b1, 2'b00, 1'b0, ad}));
    while (!a_rvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("a_rd_latency", 64'(k), 64'(A_RD + 1));
    @(posedge clk); #1;
    check("a_rvalid_width", 64'({a_rvalid, a_ready}), 64'({1'b0, 1'b1}));
  endtask

  task automatic c_issue(input logic w, input logic [19:0] ad, input logic [31:0] d,
                         input logic [3:0] b);
    int t = 0;
    @(negedge clk);
    while (!c_ready && t < 100) begin @(negedge clk); t++; end
    check("c_ready_wait", 64'(c_ready), 64'(1));
    c_req = 1'b1; c_we = w; c_addr = ad; c_wdata = d; c_be = b;
    @(posedge clk); #1;
    c_req = 1'b0;
  endtask

  task automatic c_read(input logic [19:0] ad, input logic [31:0] exp);
    int k = 0;
    c_exp_q.push_back(exp);
    c_issue(1'b0, ad, 32'h0, 4'h0);
    while (!c_rvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("c_rd_latency", 64'(k), 64'(C_RD + 1));
  endtask

  initial begin : stim
    int last, cyc_last_we, tog;
    logic [17:0] ra;
    logic [15:0] rd;
    logic [1:0]  rb;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
    #3;
    check("a_reset_outputs",
          64'({a_ready, a_rvalid, a_rdata, a_sa, a_dqo, a_dqoe, a_ce, a_oe, a_we_n, a_be_n}),
          64'({1'b1, 1'b0, 16'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11}));
    check("a_reset_state", 64'(a_st), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // basic write then read back
    a_write(18'h00010, 16'hA55A, 2'b11);
    a_read(18'h00010);

    // top address and byte lanes
    a_write(18'h3FFFF, 16'hFFFF, 2'b11);
    a_write(18'h3FFFF, 16'h1200, 2'b10);
    a_read(18'h3FFFF);

    // all-zero byte enables still run a full write cycle
    a_write(18'h00055, 16'hBEEF, 2'b11);
    a_write(18'h00055, 16'h0000, 2'b00);
    check("a_rdata_hold", 64'(a_rdata), 64'(16'h12FF));
    a_read(18'h00055);

    for (int i = 0; i < 4; i++) begin
      ra = 18'($urandom_range(0, 262143));
      rd = 16'($urandom_range(0, 65535));
      rb = 2'($urandom_range(0, 3));
      a_write(ra, rd, rb);
      a_read(ra);
    end

    // reset in the second WR cycle
    a_write(18'h00020, 16'h1111, 2'b11);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00020; a_wdata = 16'h2222; a_be = 2'b11;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("a_abort_strobes", 64'({a_ce, a_oe, a_we_n, a_be_n, a_dqoe, a_rvalid}),
          64'({1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0}));
    check("a_abort_regs", 64'({a_rdata, a_sa, a_dqo, a_st}), 64'({16'h0, 18'h0, 16'h0, 2'd0}));
    @(posedge clk); #2;
    rst = 1'b0;
    check("a_ready_after_reset", 64'(a_ready), 64'(1));
    a_read(18'h00020);

    // back-to-back commands with req held high
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 18'($urandom_range(0, 262143));
    b_wdata = 16'($urandom_range(0, 65535)); b_be = 2'b11;
    last = -1; cyc_last_we = 0; tog = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (b_ready) begin
        if (last >= 0) check("b_spacing", 64'(cyc - last), 64'(cyc_last_we != 0 ? 3 : 2));
        last = cyc; cyc_last_we = int'(b_we); tog = 1;
      end
      @(negedge clk);
      if (tog != 0) begin
        b_we = ~b_we;
        b_addr = 18'($urandom_range(0, 262143));
        b_wdata = 16'($urandom_range(0, 65535));
        tog = 0;
      end
    end
    b_req = 1'b0;

    // wide build: four byte lanes, longer read
    c_issue(1'b1, 20'hFFFFF, 32'h11223344, 4'hF);
    check("c_wr_bus", 64'({c_ce, c_we_n, c_oe, c_be_n, c_dqoe, c_dqo}),
          64'({1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 32'h11223344}));
    c_issue(1'b1, 20'hFFFFF, 32'hAABBCCDD, 4'b0101);
    check("c_wr_be", 64'(c_be_n), 64'(4'b1010));
    c_read(20'hFFFFF, 32'h11BB33DD);
    c_issue(1'b1, 20'h00001, 32'hCAFEF00D, 4'b1010);
    c_read(20'h00001, 32'hCA00F000);

    repeat (4) @(negedge clk);
    check("a_queue_drained", 64'(a_exp_q.size()), 64'(0));
    check("c_queue_drained", 64'(c_exp_q.size()), 64'(0));
    check("oe_dq_conflicts", 64'(conflicts), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
